mem_port_arbiter: RTL

//  Shares one SRAM-like memory port between the IF-stage instruction requester and the
//  EX/MEM data requester. Grants one address phase per cycle, locks the grant until

---
 rtl/mem_port_arbiter_pkg.sv | 52 +++++
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter_arb_id_fifo.sv | 77 +++++++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: owner IDs, size codes, FSM states,
// bus widths and the shared-port command payload.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned SIZE_W = 2;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic              wr;
        logic [SIZE_W-1:0] size;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Owner selection; on contention round-robin picks the non-last owner,
    // otherwise data wins.
    function automatic owner_e pick_owner(input logic   inst_req,
                                          input logic   data_req,
                                          input owner_e last_owner,
                                          input logic   rr_en);
        owner_e sel;
        sel = OWN_INST;
        if (data_req && !inst_req) begin
            sel = OWN_DATA;
        end else if (data_req && inst_req) begin
            if (rr_en) begin
                sel = (last_owner == OWN_INST) ? OWN_DATA : OWN_INST;
            end else begin
                sel = OWN_DATA;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and shared-memory-port handshake bundle. The arbiter uses the slave
// modport; the surrounding pipeline/bus-bridge environment uses master.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic              data_wr;
    logic [SIZE_W-1:0] data_size;
    logic [STRB_W-1:0] data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    logic              mem_req;
    logic              mem_wr;
    logic [SIZE_W-1:0] mem_size;
    logic [STRB_W-1:0] mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_arb_id_fifo.sv
// In-order owner ID FIFO: one 1-bit entry per accepted, unanswered transaction.
module arb_id_fifo
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  owner_e                       push_owner,
    input  logic                         pop,
    output owner_e                       head_owner,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    owner_e             entries_q [DEPTH];
    owner_e             entries_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign head_owner = entries_q[rd_ptr_q];
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push) begin
            entries_d[wr_ptr_q] = push_owner;
            wr_ptr_d            = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State register; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= OWN_INST;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            entries_q <= entries_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between the instruction and data requesters.
// One address phase per cycle, grant locked until mem_addr_ok, owners of
// accepted requests tracked in order so responses are steered back.
// Optional feature macro: ARB_RR_EN (round-robin on contention instead of
// data-first fixed priority).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus,
    output logic                 busy,
    output logic                 protocol_err
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_state_e         state_q, state_d;
    owner_e             held_owner_q, held_owner_d;
    logic               protocol_err_q, protocol_err_d;
    owner_e             pick_now;
    logic               grant_valid;
    owner_e             grant_owner;
    logic               push;
    logic               pop;
    mem_cmd_t           cmd;
    owner_e             head_owner;
    logic               id_full;
    logic               id_empty;
    logic [CNT_W-1:0]   id_count;

`ifdef ARB_RR_EN
    owner_e             last_owner_q, last_owner_d;

    assign pick_now = pick_owner(bus.inst_req, bus.data_req, last_owner_q, 1'b1);

    // Round-robin history follows every accepted address phase.
    always_comb begin
        last_owner_d = last_owner_q;
        if (push) begin
            last_owner_d = grant_owner;
        end
    end

    // Round-robin history register.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner_q <= OWN_INST;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    assign pick_now = pick_owner(bus.inst_req, bus.data_req, OWN_INST, 1'b0);
`endif

    // Arbiter FSM: grant in IDLE when not full, lock the grant in HOLD.
    always_comb begin
        state_d      = state_q;
        held_owner_d = held_owner_q;
        grant_valid  = 1'b0;
        grant_owner  = OWN_INST;
        push         = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (!reset && !id_full && (bus.inst_req || bus.data_req)) begin
                    grant_valid = 1'b1;
                    grant_owner = pick_now;
                    if (bus.mem_addr_ok) begin
                        push = 1'b1;
                    end else begin
                        state_d      = ARB_HOLD;
                        held_owner_d = pick_now;
                    end
                end
            end
            ARB_HOLD: begin
                if (!reset) begin
                    grant_valid = 1'b1;
                    grant_owner = held_owner_q;
                    if (bus.mem_addr_ok) begin
                        push    = 1'b1;
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Response steering and sticky error for responses with nothing outstanding.
    always_comb begin
        pop            = !reset && bus.mem_data_ok && !id_empty;
        protocol_err_d = protocol_err_q || (!reset && bus.mem_data_ok && id_empty);
    end

    // Shared-port command mux; instruction fetches are always word loads.
    always_comb begin
        cmd = '0;
        if (grant_valid) begin
            if (grant_owner == OWN_DATA) begin
                cmd.wr    = bus.data_wr;
                cmd.size  = bus.data_size;
                cmd.wstrb = bus.data_wstrb;
                cmd.addr  = bus.data_addr;
                cmd.wdata = bus.data_wdata;
            end else begin
                cmd.wr    = 1'b0;
                cmd.size  = SIZE_WORD;
                cmd.wstrb = '0;
                cmd.addr  = bus.inst_addr;
                cmd.wdata = '0;
            end
        end
    end

    assign bus.mem_req      = grant_valid;
    assign bus.mem_wr       = cmd.wr;
    assign bus.mem_size     = cmd.size;
    assign bus.mem_wstrb    = cmd.wstrb;
    assign bus.mem_addr     = cmd.addr;
    assign bus.mem_wdata    = cmd.wdata;

    assign bus.inst_addr_ok = grant_valid && bus.mem_addr_ok && (grant_owner == OWN_INST);
    assign bus.data_addr_ok = grant_valid && bus.mem_addr_ok && (grant_owner == OWN_DATA);
    assign bus.inst_data_ok = pop && (head_owner == OWN_INST);
    assign bus.data_data_ok = pop && (head_owner == OWN_DATA);
    assign bus.inst_rdata   = bus.mem_rdata;
    assign bus.data_rdata   = bus.mem_rdata;

    assign busy         = (id_count != '0);
    assign protocol_err = protocol_err_q;

    // FSM, held owner and error flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ARB_IDLE;
            held_owner_q   <= OWN_INST;
            protocol_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            held_owner_q   <= held_owner_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_owner (grant_owner),
        .pop        (pop),
        .head_owner (head_owner),
        .full       (id_full),
        .empty      (id_empty),
        .count      (id_count)
    );

endmodule
